// File: rtl/param_stack.sv
// LIFO stack primitive. Tracks occupancy, raises programmable almost-full and
// almost-empty flags, and holds a registered copy of the top entry so TOP is
// available without a memory read on the output path. A simultaneous push and
// pop on a non-empty stack overwrites the top entry in one cycle.
module param_stack #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  PUSH,
    input  logic                  POP,
    input  logic                  FLUSH,
    input  logic                  CLR_ERR,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic [DATA_WIDTH-1:0] TOP,
    output logic [DATA_WIDTH-1:0] POP_DATA,
    output logic                  POP_VALID,
    output logic [CW-1:0]         COUNT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]         count_reg, count_next;
    logic [DATA_WIDTH-1:0] top_reg, top_next;
    logic [DATA_WIDTH-1:0] pop_data_reg, pop_data_next;
    logic                  pop_valid_reg, pop_valid_next;
    logic                  full_reg, full_next;
    logic                  empty_reg, empty_next;
    logic                  almost_full_reg, almost_full_next;
    logic                  almost_empty_reg, almost_empty_next;
    logic                  overflow_reg, overflow_next;
    logic                  underflow_reg, underflow_next;

    logic                  is_empty;
    logic                  is_full;
    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [DATA_WIDTH-1:0] below_top;

    assign is_empty = (count_reg == '0);
    assign is_full  = (count_reg == CW'(DEPTH));

    // Entry just beneath the top; becomes the new TOP after a plain pop.
    always_comb begin
        below_top = '0;
        if (count_reg >= CW'(2)) begin
            below_top = mem[AW'(count_reg - CW'(2))];
        end
    end

    // Decode the request by priority: flush, replace, push, pop.
    always_comb begin
        count_next     = count_reg;
        top_next       = top_reg;
        pop_data_next  = pop_data_reg;
        pop_valid_next = 1'b0;
        mem_we         = 1'b0;
        mem_waddr      = AW'(count_reg);
        overflow_next  = overflow_reg & ~CLR_ERR;
        underflow_next = underflow_reg & ~CLR_ERR;

        if (FLUSH) begin
            count_next = '0;
            top_next   = '0;
        end else if (PUSH && POP) begin
            if (!is_empty) begin
                // Replace-top: occupancy unchanged, never an overflow.
                pop_data_next  = top_reg;
                pop_valid_next = 1'b1;
                mem_we         = 1'b1;
                mem_waddr      = AW'(count_reg - CW'(1));
                top_next       = DATA_IN;
            end else begin
                // Nothing to pop: the push half still goes through.
                mem_we         = 1'b1;
                mem_waddr      = '0;
                count_next     = CW'(1);
                top_next       = DATA_IN;
                underflow_next = 1'b1;
            end
        end else if (PUSH) begin
            if (!is_full) begin
                mem_we     = 1'b1;
                count_next = count_reg + CW'(1);
                top_next   = DATA_IN;
            end else begin
                overflow_next = 1'b1;
            end
        end else if (POP) begin
            if (!is_empty) begin
                pop_data_next  = top_reg;
                pop_valid_next = 1'b1;
                count_next     = count_reg - CW'(1);
                top_next       = below_top;
            end else begin
                underflow_next = 1'b1;
            end
        end
    end

    // Status flags follow the occupancy that will hold after this edge.
    always_comb begin
        full_next         = (count_next == CW'(DEPTH));
        empty_next        = (count_next == '0);
        almost_full_next  = (int'(count_next) >= AF_LEVEL);
        almost_empty_next = (int'(count_next) <= AE_LEVEL);
    end

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= DATA_IN;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_reg        <= '0;
            top_reg          <= '0;
            pop_data_reg     <= '0;
            pop_valid_reg    <= 1'b0;
            full_reg         <= 1'b0;
            empty_reg        <= 1'b1;
            almost_full_reg  <= (AF_LEVEL <= 0);
            almost_empty_reg <= 1'b1;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else begin
            count_reg        <= count_next;
            top_reg          <= top_next;
            pop_data_reg     <= pop_data_next;
            pop_valid_reg    <= pop_valid_next;
            full_reg         <= full_next;
            empty_reg        <= empty_next;
            almost_full_reg  <= almost_full_next;
            almost_empty_reg <= almost_empty_next;
            overflow_reg     <= overflow_next;
            underflow_reg    <= underflow_next;
        end
    end

    assign TOP          = top_reg;
    assign POP_DATA     = pop_data_reg;
    assign POP_VALID    = pop_valid_reg;
    assign COUNT        = count_reg;
    assign FULL         = full_reg;
    assign EMPTY        = empty_reg;
    assign ALMOST_FULL  = almost_full_reg;
    assign ALMOST_EMPTY = almost_empty_reg;
    assign OVERFLOW     = overflow_reg;
    assign UNDERFLOW    = underflow_reg;

endmodule

// File: tb/tb_param_stack.sv
// Bench for param_stack (default parameters): directed vector table, random
// traffic against a queue-based reference stack, and a mid-cycle reset.
module tb_param_stack;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFL   = DEPTH - 2;
    localparam int AEL   = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          PUSH = 1'b0, POP = 1'b0, FLUSH = 1'b0, CLR_ERR = 1'b0;
    logic [DW-1:0] DATA_IN = '0;
    logic [DW-1:0] TOP, POP_DATA;
    logic          POP_VALID;
    logic [CW-1:0] COUNT;
    logic          FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;

    int n_checks = 0;
    int n_fail   = 0;

    param_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
        .CLK(CLK), .RST_N(RST_N), .PUSH(PUSH), .POP(POP), .FLUSH(FLUSH),
        .CLR_ERR(CLR_ERR), .DATA_IN(DATA_IN), .TOP(TOP), .POP_DATA(POP_DATA),
        .POP_VALID(POP_VALID), .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY),
        .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    // Reference model: a plain queue whose back is the top of stack.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_pd;
    bit            m_pv, m_ovf, m_unf;

    task automatic model_reset();
        m_q.delete();
        m_pd = '0; m_pv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic model_step(input bit pu, input bit po, input bit fl, input bit ce,
                              input logic [DW-1:0] d);
        if (ce) begin m_ovf = 1'b0; m_unf = 1'b0; end
        m_pv = 1'b0;
        if (fl) begin
            m_q.delete();
        end else if (pu && po) begin
            if (m_q.size() > 0) begin
                m_pd = m_q[m_q.size()-1];
                m_q[m_q.size()-1] = d;
                m_pv = 1'b1;
            end else begin
                m_q.push_back(d);
                m_unf = 1'b1;
            end
        end else if (pu) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else m_ovf = 1'b1;
        end else if (po) begin
            if (m_q.size() > 0) begin
                m_pd = m_q.pop_back();
                m_pv = 1'b1;
            end else begin
                m_unf = 1'b1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; returns #1 after the active edge.
    task automatic cycle(input bit pu, input bit po, input bit fl, input bit ce,
                         input logic [DW-1:0] d);
        PUSH = pu; POP = po; FLUSH = fl; CLR_ERR = ce; DATA_IN = d;
        @(posedge CLK);
        model_step(pu, po, fl, ce, d);
        #1;
        PUSH = 1'b0; POP = 1'b0; FLUSH = 1'b0; CLR_ERR = 1'b0;
    endtask

    // Compare every output with the reference model.
    task automatic check_model(input string tag);
        int sz;
        logic [DW-1:0] t;
        sz = m_q.size();
        t  = (sz > 0) ? m_q[sz-1] : '0;
        chk({tag, ".count"}, 32'(COUNT), 32'(sz));
        chk({tag, ".top"}, 32'(TOP), 32'(t));
        chk({tag, ".pop_valid"}, 32'(POP_VALID), 32'(m_pv));
        chk({tag, ".pop_data"}, 32'(POP_DATA), 32'(m_pd));
        chk({tag, ".flags"}, 32'({FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY}),
            32'({sz == DEPTH, sz == 0, sz >= AFL, sz <= AEL}));
        chk({tag, ".errors"}, 32'({OVERFLOW, UNDERFLOW}), 32'({m_ovf, m_unf}));
    endtask

    typedef struct {
        bit            pu, po, fl, ce;
        logic [DW-1:0] d;
        int            cnt;
        logic [DW-1:0] top;
        bit            pv;
        logic [DW-1:0] pd;
        logic [3:0]    flg;   // {FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY}
        bit            ovf, unf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit pu, input bit po, input bit fl, input bit ce,
                                input logic [DW-1:0] d, input int cnt, input logic [DW-1:0] top,
                                input bit pv, input logic [DW-1:0] pd, input logic [3:0] flg,
                                input bit ovf, input bit unf);
        vec_t v;
        v.pu = pu; v.po = po; v.fl = fl; v.ce = ce; v.d = d; v.cnt = cnt; v.top = top;
        v.pv = pv; v.pd = pd; v.flg = flg; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    initial begin
        // Push three, pop three.
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,8'h11, 1,8'h11,1'b0,8'h00,4'b0001,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,8'h22, 2,8'h22,1'b0,8'h00,4'b0001,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,8'h33, 3,8'h33,1'b0,8'h00,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h00, 2,8'h22,1'b1,8'h33,4'b0001,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h00, 1,8'h11,1'b1,8'h22,4'b0001,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h00, 0,8'h00,1'b1,8'h11,4'b0101,1'b0,1'b0));
        // Underflow, then push+pop on empty acts as push.
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h00, 0,8'h00,1'b0,8'h00,4'b0101,1'b0,1'b1));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,8'h5A, 1,8'h5A,1'b0,8'h00,4'b0001,1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,8'h00, 1,8'h5A,1'b0,8'h00,4'b0001,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00, 0,8'h00,1'b0,8'h00,4'b0101,1'b0,1'b0));
        // Clear and a new underflow in the same cycle: set wins.
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b1,8'h00, 0,8'h00,1'b0,8'h00,4'b0101,1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,8'h00, 0,8'h00,1'b0,8'h00,4'b0101,1'b0,1'b0));
        // Fill to DEPTH.
        for (int k = 0; k < DEPTH; k++)
            vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,8'(k), k+1, 8'(k), 1'b0, 8'h00,
                              {k+1 == DEPTH, 1'b0, k+1 >= AFL, k+1 <= AEL}, 1'b0, 1'b0));
        // Overflow and clear.
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,8'hAA,16,8'h0F,1'b0,8'h00,4'b1010,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,8'h00,16,8'h0F,1'b0,8'h00,4'b1010,1'b0,1'b0));
        // Replace-top while full, then pops.
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,8'hC3,16,8'hC3,1'b1,8'h0F,4'b1010,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h00,15,8'h0E,1'b1,8'hC3,4'b0010,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h00,14,8'h0D,1'b1,8'h0E,4'b0010,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h00,13,8'h0C,1'b1,8'h0D,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00, 0,8'h00,1'b0,8'h00,4'b0101,1'b0,1'b0));
        // Five pushes, then flush beats a simultaneous push.
        for (int k = 1; k <= 5; k++)
            vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,8'(k), k, 8'(k), 1'b0, 8'h00,
                              {1'b0, 1'b0, 1'b0, k <= AEL}, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,8'h99, 0,8'h00,1'b0,8'h00,4'b0101,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b1,1'b0,8'h98, 0,8'h00,1'b0,8'h00,4'b0101,1'b0,1'b0));

        model_reset();

        // Reset state.
        #12;
        chk("reset.count", 32'(COUNT), 32'd0);
        chk("reset.top", 32'(TOP), 32'd0);
        chk("reset.pop_data", 32'(POP_DATA), 32'd0);
        chk("reset.pop_valid", 32'(POP_VALID), 32'd0);
        chk("reset.flags", 32'({FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY}), 32'b0101);
        chk("reset.errors", 32'({OVERFLOW, UNDERFLOW}), 32'd0);
        RST_N = 1'b1;

        // Directed vector table.
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].pu, vecs[i].po, vecs[i].fl, vecs[i].ce, vecs[i].d);
            chk($sformatf("vec%0d.count", i), 32'(COUNT), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d.top", i), 32'(TOP), 32'(vecs[i].top));
            chk($sformatf("vec%0d.pop_valid", i), 32'(POP_VALID), 32'(vecs[i].pv));
            if (vecs[i].pv)
                chk($sformatf("vec%0d.pop_data", i), 32'(POP_DATA), 32'(vecs[i].pd));
            chk($sformatf("vec%0d.flags", i), 32'({FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY}),
                32'(vecs[i].flg));
            chk($sformatf("vec%0d.errors", i), 32'({OVERFLOW, UNDERFLOW}),
                32'({vecs[i].ovf, vecs[i].unf}));
        end

        // Random traffic, alternating push-heavy and pop-heavy phases.
        for (int i = 0; i < 800; i++) begin
            int bias;
            bit pu, po, fl, ce;
            bias = ((i / 60) % 2 == 0) ? 75 : 25;
            pu = ($urandom_range(0, 99) < bias);
            po = ($urandom_range(0, 99) >= bias);
            fl = ($urandom_range(0, 99) < 2);
            ce = ($urandom_range(0, 99) < 6);
            cycle(pu, po, fl, ce, 8'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        // Asynchronous reset in the middle of a cycle.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h40 + 8'(k));
        chk("prerst.count", 32'(COUNT), 32'd4);
        chk("prerst.top", 32'(TOP), 32'h43);
        #3;
        RST_N = 1'b0;
        #1;
        model_reset();
        chk("midrst.count", 32'(COUNT), 32'd0);
        chk("midrst.top", 32'(TOP), 32'd0);
        chk("midrst.pop_valid", 32'(POP_VALID), 32'd0);
        chk("midrst.flags", 32'({FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY}), 32'b0101);
        @(posedge CLK);
        #2;
        RST_N = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
        chk("postrst.count", 32'(COUNT), 32'd1);
        chk("postrst.top", 32'(TOP), 32'h77);
        check_model("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
